xin_literal_fetch: RTL and testbench

Sequencer between an input-literal ROM (combinational, one DATA_WIDTH word per address, features followed by their complements) and the clause-evaluation datapath. On a start pulse it walks ROM addresses 0..ROM_DEPTH-1 and registers each word into an output stage with a valid/ready handshake, at one word per cycle when there is no backpressure. It also counts the set literals delivered, so a bench or the controller can sanity-check the literal vector.

---
 rtl/xin_literal_fetch.sv | 140 ++++++++++++++
 tb/tb_xin_literal_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xin_literal_fetch.sv
// rtl/xin_literal_fetch.sv - streams one sample of literal ROM words through a valid/ready output stage
module xin_literal_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int ROM_DEPTH  = 49,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  ones_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_rom_addr;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic [ADDR_WIDTH-1:0]   r_out_idx;
    logic                    r_out_last;
    logic                    r_done;
    logic [CNT_WIDTH-1:0]    r_ones_count;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_load_last;
    logic                    w_start_ok;

    function automatic logic [CNT_WIDTH-1:0] f_popcount(input logic [DATA_WIDTH-1:0] d);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + CNT_WIDTH'(d[i]);
        end
        return c;
    endfunction

    // A load refills the output register whenever it is empty or draining this cycle,
    // which is what keeps the stream at one word per cycle without a bubble.
    assign w_accept    = r_out_valid && out_ready;
    assign w_load      = (r_state == S_FETCH) && (!r_out_valid || out_ready);
    assign w_load_last = w_load && (r_rom_addr == LAST_ADDR);
    assign w_start_ok  = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> FETCH on start, FETCH -> DRAIN on loading the last word,
    // DRAIN -> IDLE once the last word is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_load_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address counter, output stage, done pulse and popcount of accepted words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr   <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
            r_done       <= 1'b0;
            r_ones_count <= '0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_accept;

            if (w_start_ok) begin
                r_rom_addr   <= '0;
                r_ones_count <= '0;
            end else if (w_accept) begin
                r_ones_count <= r_ones_count + f_popcount(r_out_data);
            end

            if (w_load) begin
                r_out_data  <= rom_data;
                r_out_idx   <= r_rom_addr;
                r_out_last  <= w_load_last;
                r_out_valid <= 1'b1;
                // The address parks on the last word so the ROM is never driven past its end.
                if (!w_load_last) begin
                    r_rom_addr <= r_rom_addr + 1'b1;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign rom_addr   = r_rom_addr;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign done       = r_done;
    assign ones_count = r_ones_count;

endmodule

// File: tb/tb_xin_literal_fetch.sv
// tb/tb_xin_literal_fetch.sv - directed self-checking bench for xin_literal_fetch
module tb_xin_literal_fetch;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 49;
    localparam int CW    = 11;
    localparam int NFEAT = 784;

    localparam int M_FULL    = 0;
    localparam int M_RAND    = 1;
    localparam int M_HOLD10  = 2;
    localparam int M_RESTART = 3;
    localparam int M_RST     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic          busy;
    logic          out_valid;
    logic          out_last;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic [CW-1:0] ones_count;

    logic [DW-1:0]         rom [0:DEPTH-1];
    logic [DEPTH*DW-1:0]   lit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data = (int'(rom_addr) < DEPTH) ? rom[int'(rom_addr)] : '0;

    xin_literal_fetch #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ROM_DEPTH (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .ones_count(ones_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == M_RAND)   return 1'($urandom_range(0, 1));
        if (mode == M_HOLD10) return (cyc >= 10);
        return 1'b1;
    endfunction

    // Called at posedge+1 with the DUT idle (or in its done cycle); drives start now.
    task automatic run_sample(input int mode);
        int            cyc;
        int            exp_idx;
        int            last_hs;
        logic          got_done;
        logic          stall;
        logic [DW-1:0] s_data;
        logic [AW-1:0] s_idx;
        logic          s_last;
        cyc      = 0;
        exp_idx  = 0;
        last_hs  = -10;
        got_done = 1'b0;
        stall    = 1'b0;
        s_data   = '0;
        s_idx    = '0;
        s_last   = 1'b0;
        start     = 1'b1;
        out_ready = pick_ready(mode, 0);
        while (!got_done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (mode == M_RESTART) && (cyc == 5 || cyc == 20);

            if (cyc == 1) begin
                check("start_busy", 64'(busy), 64'(1));
                check("start_rom_addr", 64'(rom_addr), 64'(0));
                check("start_ones_clear", 64'(ones_count), 64'(0));
                check("start_valid", 64'(out_valid), 64'(0));
            end

            if (stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(s_data));
                check("stall_idx", 64'(out_idx), 64'(s_idx));
                check("stall_last", 64'(out_last), 64'(s_last));
            end

            if (done) begin
                got_done = 1'b1;
                check("done_after_last_hs", 64'(cyc), 64'(last_hs + 1));
                check("words_delivered", 64'(exp_idx), 64'(DEPTH));
                check("ones_count_final", 64'(ones_count), 64'(NFEAT));
                check("done_busy", 64'(busy), 64'(0));
                check("done_valid", 64'(out_valid), 64'(0));
                if (mode == M_FULL || mode == M_RESTART) begin
                    check("start_to_done", 64'(cyc), 64'(DEPTH + 2));
                end
            end

            if (mode == M_HOLD10 && cyc == 10) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_idx", 64'(out_idx), 64'(0));
                check("hold_rom_addr", 64'(rom_addr), 64'(1));
            end

            if (mode == M_RST && out_valid && out_idx == AW'(20)) begin
                rst   = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                rst   = 1'b0;
                start = 1'b0;
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_valid", 64'(out_valid), 64'(0));
                check("rst_data", 64'(out_data), 64'(0));
                check("rst_idx", 64'(out_idx), 64'(0));
                check("rst_last", 64'(out_last), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                check("rst_rom_addr", 64'(rom_addr), 64'(0));
                check("rst_ones", 64'(ones_count), 64'(0));
                @(posedge clk);
                #1;
                check("rst_no_done", 64'(done), 64'(0));
                check("rst_start_ignored", 64'(busy), 64'(0));
                return;
            end

            out_ready = pick_ready(mode, cyc);
            stall  = out_valid && !out_ready;
            s_data = out_data;
            s_idx  = out_idx;
            s_last = out_last;
            if (out_valid && out_ready) begin
                check("hs_idx", 64'(out_idx), 64'(exp_idx));
                check("hs_data", 64'(out_data), 64'(rom[exp_idx]));
                check("hs_last", 64'(out_last), 64'(exp_idx == DEPTH - 1));
                if (mode == M_FULL || mode == M_RESTART) begin
                    check("hs_cycle", 64'(cyc), 64'(exp_idx + 2));
                end
                exp_idx++;
                last_hs = cyc;
            end
        end
        if (!got_done) begin
            check("timeout_waiting_done", 64'(0), 64'(1));
        end
    endtask

    initial begin
        for (int i = 0; i < NFEAT; i++) begin
            lit[i]         = 1'($urandom_range(0, 1));
            lit[NFEAT + i] = ~lit[i];
        end
        for (int k = 0; k < DEPTH; k++) begin
            rom[k] = lit[k*DW +: DW];
        end

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_rom_addr", 64'(rom_addr), 64'(0));
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_idx", 64'(out_idx), 64'(0));
        check("reset_last", 64'(out_last), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_ones", 64'(ones_count), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'(0));

        run_sample(M_FULL);
        run_sample(M_FULL);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("ones_hold_idle", 64'(ones_count), 64'(NFEAT));

        run_sample(M_RAND);
        run_sample(M_HOLD10);
        run_sample(M_RESTART);
        run_sample(M_RST);
        run_sample(M_FULL);
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
